// File: rtl/wb_port_arbiter_if.sv
// Bundle of write-back arbiter signals: pipeline WB request, long-unit
// result handshake, and the arbitrated register-file write port.
interface wb_port_arbiter_if;
    logic        pipe_wen;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_data;
    logic        lu_valid;
    logic [4:0]  lu_rd;
    logic [31:0] lu_data;
    logic        lu_ready;
    logic        Stall;
    logic        rf_wen;
    logic [4:0]  rf_rd;
    logic [31:0] rf_data;
    logic [1:0]  fifo_count;

    // Driver side: pipeline and long unit
    modport master (
        output pipe_wen, pipe_rd, pipe_data, lu_valid, lu_rd, lu_data,
        input  lu_ready, Stall, rf_wen, rf_rd, rf_data, fifo_count
    );

    // Arbiter side
    modport slave (
        input  pipe_wen, pipe_rd, pipe_data, lu_valid, lu_rd, lu_data,
        output lu_ready, Stall, rf_wen, rf_rd, rf_data, fifo_count
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// Single register-file write port shared between the WB stage and a
// long-latency unit. Long-unit results wait in a 2-entry FIFO; the pipe has
// priority, but a head entry that waits STARVE_LIMIT cycles forces a one-cycle
// pipeline stall so it gets written.
module wb_port_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input logic              clk,
    input logic              rst,
    wb_port_arbiter_if.slave bus
);
    typedef enum logic {S_PASS = 1'b0, S_FORCE = 1'b1} state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t      r_state;
    state_t      w_state_next;
    logic [1:0]  r_count;
    logic        r_wr_ptr;
    logic        r_rd_ptr;
    logic [3:0]  r_starve;
    logic [4:0]  r_mem_rd   [2];
    logic [31:0] r_mem_data [2];

    logic        w_nonempty;
    logic [4:0]  w_head_rd;
    logic [31:0] w_head_data;
    logic        w_lu_ready;
    logic        w_push;
    logic        w_pop;
    logic        w_rf_wen;
    logic [4:0]  w_rf_rd;
    logic [31:0] w_rf_data;
    logic        w_stall;

    assign w_nonempty  = (r_count != 2'd0);
    assign w_head_rd   = r_mem_rd[r_rd_ptr];
    assign w_head_data = r_mem_data[r_rd_ptr];

    // Ready depends only on registered occupancy (and reset), never on lu_valid.
    assign w_lu_ready = !rst && (r_count != 2'd2);
    // Results targeting x0 complete the handshake but are never stored.
    assign w_push     = bus.lu_valid && w_lu_ready && (bus.lu_rd != 5'd0);

    // FIFO storage: each entry captures the long-unit result when it is the write target
    for (genvar gi = 0; gi < 2; gi++) begin : g_entry
        always_ff @(posedge clk) begin
            if (w_push && (r_wr_ptr == 1'(gi))) begin
                r_mem_rd[gi]   <= bus.lu_rd;
                r_mem_data[gi] <= bus.lu_data;
            end
        end
    end

    // FIFO pointers, occupancy and starvation counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
            r_starve <= 4'd0;
        end else begin
            if (w_push) r_wr_ptr <= ~r_wr_ptr;
            if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
            r_count <= r_count + 2'(w_push) - 2'(w_pop);
            if (w_pop || !w_nonempty)
                r_starve <= 4'd0;
            else if (r_state == S_PASS && r_starve < LIMIT)
                r_starve <= r_starve + 4'd1;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_PASS;
        else     r_state <= w_state_next;
    end

    // FSM next state: force the head in once it has starved while the pipe keeps the port
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_PASS: begin
                // A WAW discard this cycle empties the head, so no force is needed then.
                if (bus.pipe_wen && w_nonempty && (r_starve == LIMIT) && !w_pop)
                    w_state_next = S_FORCE;
            end
            S_FORCE: w_state_next = S_PASS;
            default: w_state_next = S_PASS;
        endcase
    end

    // FSM outputs: zero-latency write-port mux and FIFO pop decision
    always_comb begin
        w_rf_wen  = 1'b0;
        w_rf_rd   = 5'd0;
        w_rf_data = 32'd0;
        w_pop     = 1'b0;
        w_stall   = 1'b0;
        if (!rst) begin
            if (r_state == S_FORCE) begin
                w_stall = 1'b1;
                if (w_nonempty) begin
                    w_rf_wen  = 1'b1;
                    w_rf_rd   = w_head_rd;
                    w_rf_data = w_head_data;
                    w_pop     = 1'b1;
                end
            end else if (bus.pipe_wen) begin
                w_rf_wen  = 1'b1;
                w_rf_rd   = bus.pipe_rd;
                w_rf_data = bus.pipe_data;
                // Older buffered write to the same register is dead; drop it.
                w_pop     = w_nonempty && (w_head_rd == bus.pipe_rd);
            end else if (w_nonempty) begin
                w_rf_wen  = 1'b1;
                w_rf_rd   = w_head_rd;
                w_rf_data = w_head_data;
                w_pop     = 1'b1;
            end
        end
    end

    assign bus.lu_ready   = w_lu_ready;
    assign bus.Stall      = w_stall;
    assign bus.rf_wen     = w_rf_wen;
    assign bus.rf_rd      = w_rf_rd;
    assign bus.rf_data    = w_rf_data;
    assign bus.fifo_count = r_count;
endmodule
